uart_tx: RTL and testbench

UART serial transmitter, the transmit-side counterpart to the UART receiver. It accepts one 5–9 bit word through a valid/ready handshake and serialises it LSB-first as start, data, optional parity and 1 or 2 stop bits. Bit timing uses the same 16x divisor convention as the receiver. It sits between the TX FIFO (or register interface) and the `tx` pad.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_if.sv | 8 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: frame encodings and TX state shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_ODD = 2'b01, PAR_EVEN = 2'b10, PAR_RSVD = 2'b11} parity_e;
  localparam logic [2:0] DB_5 = 3'b000, DB_6 = 3'b001, DB_7 = 3'b010, DB_8 = 3'b011, DB_9 = 3'b100;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  // Reserved codes fall back to 8 data bits
  function automatic logic [3:0] data_bits_n(input logic [2:0] db);
    return db == DB_5 ? 4'd5 : db == DB_6 ? 4'd6 : db == DB_7 ? 4'd7 :
           db == DB_8 ? 4'd8 : db == DB_9 ? 4'd9 : 4'd8;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word handshake into the UART transmitter
interface uart_tx_if;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-clk tick every max(divisor>>4,1) clocks, restartable
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] divisor,
  input  logic        restart,
  output logic        tick
);
  logic [15:0] cnt_q, cnt_d, tp, tp_m1;
  assign tp = divisor >> 4;
  assign tp_m1 = tp == 16'd0 ? 16'd0 : tp - 16'd1;
  assign tick = cnt_q == 16'd0;
  always_comb cnt_d = restart || tick ? tp_m1 : cnt_q - 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serialiser (start, 5-9 data LSB-first, optional parity, 1-2 stop)
module uart_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [1:0]  parity,
  input  logic [2:0]  data_bits,
  input  logic        stop_bit,
  input  logic [15:0] tx_divisor,
  uart_tx_if.slave    bus,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done
);
  import uart_pkg::*;
  tx_state_e   state_q, state_d;
  logic [8:0]  shift_q, shift_d, masked;
  logic [3:0]  nbits_q, nbits_d, bit_q, bit_d, tick_cnt_q, tick_cnt_d, n_new;
  logic        par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic [15:0] div_q, div_d;
  logic        tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic        accept, tick, bit_end;
  assign bus.tx_ready = tx_en && state_q == IDLE;
  assign accept = bus.tx_valid && bus.tx_ready;
  assign n_new = data_bits_n(data_bits);
  assign masked = bus.tx_data & ~(9'h1FF << n_new);
  assign bit_end = tick && tick_cnt_q == 4'd15;
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  // The tick generator is restarted with the incoming divisor so the start bit is a full BP
  uart_baud_tick u_tick (.clk, .rst_n, .divisor(accept ? tx_divisor : div_q), .restart(accept), .tick);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    nbits_d = nbits_q;
    bit_d = bit_q;
    par_en_d = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d = stop2_q;
    div_d = div_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        shift_d = masked;
        nbits_d = n_new;
        par_en_d = parity == PAR_ODD || parity == PAR_EVEN;
        par_bit_d = parity == PAR_ODD ? ~^masked : ^masked;
        stop2_d = stop_bit;
        div_d = tx_divisor;
        tick_cnt_d = '0;
        bit_d = '0;
        tx_d = 1'b0;
        busy_d = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == nbits_q - 4'd1) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d = par_en_q ? par_bit_q : 1'b1;
          bit_d = '0;
        end else begin
          shift_d = shift_q >> 1;
          tx_d = shift_q[1];
          bit_d = bit_q + 4'd1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_q[0] == stop2_q) begin
          state_d = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else bit_d = bit_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      nbits_q <= '0;
      bit_q <= '0;
      tick_cnt_q <= '0;
      par_en_q <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q <= 1'b0;
      div_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      nbits_q <= nbits_d;
      bit_q <= bit_d;
      tick_cnt_q <= tick_cnt_d;
      par_en_q <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q <= stop2_d;
      div_q <= div_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench, frames queued at accept and checked bit-by-bit on tx
module tb_uart_tx;
  typedef struct {
    logic [8:0] d;
    int n;
    logic [1:0] par;
    logic stop2;
    int bp;
    int acc;
    bit b2b;
  } item_t;
  logic clk = 1'b0, rst_n, tx_en, stop_bit, tx, busy, done;
  logic [1:0] parity;
  logic [2:0] data_bits;
  logic [15:0] tx_divisor;
  int cyc = 0, last_done = 0, n_chk = 0, n_bad = 0;
  bit mon_busy = 1'b0;
  item_t q[$];
  uart_tx_if bus();
  uart_tx dut (.clk(clk), .rst_n(rst_n), .tx_en(tx_en), .parity(parity), .data_bits(data_bits),
               .stop_bit(stop_bit), .tx_divisor(tx_divisor), .bus(bus), .tx(tx), .tx_busy(busy), .tx_done(done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int model_n(input logic [2:0] db);
    return db == 3'd0 ? 5 : db == 3'd1 ? 6 : db == 3'd2 ? 7 : db == 3'd4 ? 9 : 8;
  endfunction
  function automatic int model_bp(input logic [15:0] dv);
    int tp = int'(dv) / 16;
    return 16 * (tp == 0 ? 1 : tp);
  endfunction
  task automatic send(input logic [8:0] d, input bit hold, input bit push, input bit b2b);
    item_t it;
    int t = 0;
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    #1;
    while (!bus.tx_ready && t < 5000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.tx_ready) chk("ready_timeout", 0, 1);
    else if (push) begin
      it.d = d;
      it.n = model_n(data_bits);
      it.par = parity;
      it.stop2 = stop_bit;
      it.bp = model_bp(tx_divisor);
      it.acc = cyc + 1;
      it.b2b = b2b;
      q.push_back(it);
    end
    @(negedge clk);
    bus.tx_valid = hold;
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() > 0 || mon_busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size() + int'(mon_busy), 0);
  endtask
  task automatic check_frame();
    item_t it;
    logic exp_bits [0:12];
    logic mid;
    int nb, ones, bad;
    it = q.pop_front();
    mon_busy = 1'b1;
    ones = 0;
    mid = 1'bx;
    for (int i = 0; i < it.n; i++) ones += int'(it.d[i]);
    exp_bits[0] = 1'b0;
    for (int i = 0; i < it.n; i++) exp_bits[1 + i] = it.d[i];
    nb = 1 + it.n;
    if (it.par == 2'b01 || it.par == 2'b10) begin
      exp_bits[nb] = it.par == 2'b10 ? ones[0] : ~ones[0];
      nb++;
    end
    exp_bits[nb] = 1'b1;
    nb++;
    if (it.stop2) begin
      exp_bits[nb] = 1'b1;
      nb++;
    end
    chk("start_latency", cyc, it.acc);
    if (it.b2b) chk("b2b_gap", cyc - last_done, 1);
    for (int j = 0; j < nb; j++) begin
      bad = 0;
      for (int k = 0; k < it.bp; k++) begin
        if (j != 0 || k != 0) @(negedge clk);
        if (k == it.bp / 2) mid = tx;
        if (tx !== exp_bits[j] || busy !== 1'b1 || done !== 1'b0) bad++;
      end
      chk($sformatf("bit%0d", j), mid, exp_bits[j]);
      chk($sformatf("bit%0d_glitch", j), bad, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("tx_end", tx, 1);
    last_done = cyc;
    mon_busy = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n && !tx && q.size() > 0) check_frame();
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad + 1);
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    tx_en = 1'b1;
    parity = 2'b00;
    data_bits = 3'b011;
    stop_bit = 1'b0;
    tx_divisor = 16'd16;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    #12;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus.tx_ready, 1);
    tx_en = 1'b0;
    #1 chk("rst_ready_en0", bus.tx_ready, 0);
    tx_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send(9'h0A5, 0, 1, 0);
    drain();
    tx_divisor = 16'd64; data_bits = 3'b010; parity = 2'b10;
    send(9'h041, 0, 1, 0);
    drain();
    tx_divisor = 16'd32; data_bits = 3'b000; parity = 2'b01; stop_bit = 1'b1;
    send(9'h1FF, 0, 1, 0);
    drain();
    tx_divisor = 16'd16; data_bits = 3'b100; parity = 2'b00; stop_bit = 1'b0;
    send(9'h155, 1, 1, 0);
    send(9'h0AA, 0, 1, 1);
    drain();
    data_bits = 3'b011;
    send(9'h03C, 0, 1, 0);
    repeat (40) @(negedge clk);
    parity = 2'b10; data_bits = 3'b000; stop_bit = 1'b1; tx_divisor = 16'd64; tx_en = 1'b0;
    drain();
    #1 chk("ready_en0_after", bus.tx_ready, 0);
    bus.tx_valid = 1'b1;
    repeat (30) @(negedge clk);
    chk("blocked_busy", busy, 0);
    chk("blocked_tx", tx, 1);
    bus.tx_valid = 1'b0;
    tx_en = 1'b1; parity = 2'b00; data_bits = 3'b011; stop_bit = 1'b0; tx_divisor = 16'd16;
    send(9'h0F0, 0, 0, 0);
    repeat (60) @(negedge clk);
    chk("pre_arst_tx", tx, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_divisor = 16'd5;
    send(9'h0C3, 0, 1, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
